// File: rtl/gpr_arbiter.sv
// Two-port round-robin arbiter and command sequencer for the 8x16 GPR bank.
// Optional build macro GPR_ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
module gpr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [2:0]            a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [2:0]            b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  a_gnt_o,
  output logic                  b_gnt_o,
  output logic                  a_done_o,
  output logic                  b_done_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  gpr_cs_o,
  output logic                  gpr_read_o,
  output logic [ADDR_WIDTH-1:0] gpr_address_o,
  output logic [DATA_WIDTH-1:0] gpr_wdata_o,
  output logic                  gpr_wdata_oe_o,
  input  logic [DATA_WIDTH-1:0] gpr_rdata_i,
  input  logic                  gpr_rdy_i
);

  // state | meaning
  // IDLE  | bank outputs low, waiting for gpr_rdy_i and a request
  // CMD   | first cs cycle, command registers on the bank
  // XFER  | second cs cycle, read data captured on exit
  // RECOV | cs low, done pulse to the owner
  typedef enum logic [1:0] {IDLE, CMD, XFER, RECOV} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 0 = A, 1 = B
  logic                  cmd_we_q, cmd_we_d;
  logic [2:0]            cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  pick_b;
  logic                  start;
  logic                  active;

`ifdef GPR_ARB_FIXED_PRIO_EN
  assign pick_b = ~a_req_i;
`else
  logic last_b_q, last_b_d;
  assign pick_b = b_req_i & (~a_req_i | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == RECOV) last_b_d = owner_q;
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk_i) begin
    if (reset_i) last_b_q <= 1'b1;
    else         last_b_q <= last_b_d;
  end
`endif

  assign start = (state_q == IDLE) & gpr_rdy_i & (a_req_i | b_req_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CMD;
      CMD:     state_d = XFER;
      XFER:    state_d = RECOV;
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (start) begin
      owner_d     = pick_b;
      cmd_we_d    = pick_b ? b_we_i    : a_we_i;
      cmd_addr_d  = pick_b ? b_addr_i  : a_addr_i;
      cmd_wdata_d = pick_b ? b_wdata_i : a_wdata_i;
    end
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (state_q == XFER && !cmd_we_q) begin
      if (owner_q) b_rdata_d = gpr_rdata_i;
      else         a_rdata_d = gpr_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign active = (state_q == CMD) | (state_q == XFER);

  always_comb begin
    gpr_cs_o       = active;
    gpr_read_o     = active & ~cmd_we_q;
    gpr_wdata_oe_o = active & cmd_we_q;
    gpr_address_o  = active ? {{(ADDR_WIDTH-3){1'b0}}, cmd_addr_q} : '0;
    gpr_wdata_o    = active ? cmd_wdata_q : '0;
    a_gnt_o        = (state_q != IDLE) & ~owner_q;
    b_gnt_o        = (state_q != IDLE) &  owner_q;
    a_done_o       = (state_q == RECOV) & ~owner_q;
    b_done_o       = (state_q == RECOV) &  owner_q;
    a_rdata_o      = a_rdata_q;
    b_rdata_o      = b_rdata_q;
  end

endmodule

// File: tb/tb_gpr_arbiter.sv
// Directed, table-driven bench for gpr_arbiter with a small behavioural bank.
module tb_gpr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, rdy = 1;
  logic [2:0]  a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, b_gnt, a_done, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic        cs, rd, oe;
  logic [15:0] addr, wdata, bank_rdata;
  logic [15:0] mem [8];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpr_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt), .b_gnt_o(b_gnt), .a_done_o(a_done), .b_done_o(b_done),
    .a_rdata_o(a_rdata), .b_rdata_o(b_rdata),
    .gpr_cs_o(cs), .gpr_read_o(rd), .gpr_address_o(addr),
    .gpr_wdata_o(wdata), .gpr_wdata_oe_o(oe),
    .gpr_rdata_i(bank_rdata), .gpr_rdy_i(rdy)
  );

  // Bank model: writes while the arbiter drives the bus, reads are combinational.
  always @(posedge clk) if (cs && oe) mem[addr[2:0]] <= wdata;
  assign bank_rdata = (cs && rd) ? mem[addr[2:0]] : 16'h0;

  typedef struct {
    logic        ar, awe; logic [2:0] aad; logic [15:0] awd;
    logic        br, bwe; logic [2:0] bad; logic [15:0] bwd;
    logic        rdy;
    logic [70:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [70:0] pack_exp(
      input logic e_cs, e_rd, e_oe, input logic [15:0] e_addr, e_wd,
      input logic e_ag, e_bg, e_ad, e_bd, input logic [15:0] e_ard, e_brd);
    return {e_cs, e_rd, e_oe, e_addr, e_wd, e_ag, e_bg, e_ad, e_bd, e_ard, e_brd};
  endfunction

  function automatic logic [70:0] actual();
    return {cs, rd, oe, addr, wdata, a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata};
  endfunction

  task automatic v(input logic ar, awe, input logic [2:0] aad, input logic [15:0] awd,
                   input logic br, bwe, input logic [2:0] bad, input logic [15:0] bwd,
                   input logic vrdy, input logic [70:0] e);
    vec_t t;
    t.ar = ar; t.awe = awe; t.aad = aad; t.awd = awd;
    t.br = br; t.bwe = bwe; t.bad = bad; t.bwd = bwd;
    t.rdy = vrdy; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    logic exp_ag, exp_bg, exp_cs;
    int   ph, tx;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;

    // idle/zero: {cs,rd,oe,addr,wd,ag,bg,ad,bd,ard,brd}
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'h0,16'h0));
    // A writes A5A5 to reg 5; request dropped once granted
    v(1,1,5,16'hA5A5, 0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,0,1,16'h5,16'hA5A5,1,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,0,1,16'h5,16'hA5A5,1,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   1,0,1,0,16'h0,16'h0));
    // A reads reg 5
    v(1,0,5,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h5,16'h0,   1,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h5,16'h0,   1,0,0,0,16'h0,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   1,0,1,0,16'hA5A5,16'h0));
    // B writes 1234 to reg 2
    v(0,0,0,16'h0,    1,1,2,16'h1234, 1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,0,1,16'h2,16'h1234,0,1,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,0,1,16'h2,16'h1234,0,1,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,1,0,1,16'hA5A5,16'h0));
    // B reads reg 2; A's read data must be retained
    v(0,0,0,16'h0,    1,0,2,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h2,16'h0,   0,1,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h2,16'h0,   0,1,0,0,16'hA5A5,16'h0));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,1,0,1,16'hA5A5,16'h1234));
    // bank busy for 5 cycles with B requesting
    for (int i = 0; i < 5; i++)
      v(0,0,0,16'h0,  1,0,2,16'h0,    0, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'hA5A5,16'h1234));
    v(0,0,0,16'h0,    1,0,2,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'hA5A5,16'h1234));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h2,16'h0,   0,1,0,0,16'hA5A5,16'h1234));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(1,1,0,16'h2,16'h0,   0,1,0,0,16'hA5A5,16'h1234));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,1,0,1,16'hA5A5,16'h1234));
    v(0,0,0,16'h0,    0,0,0,16'h0,    1, pack_exp(0,0,0,16'h0,16'h0,   0,0,0,0,16'hA5A5,16'h1234));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      a_req = tbl[i].ar; a_we = tbl[i].awe; a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
      b_req = tbl[i].br; b_we = tbl[i].bwe; b_addr = tbl[i].bad; b_wdata = tbl[i].bwd;
      rdy = tbl[i].rdy;
      #1 check($sformatf("vec%0d", i), actual(), tbl[i].exp);
      @(negedge clk);
    end

    // Contention: both ports read continuously; last grant went to B.
    a_req = 1; a_we = 0; a_addr = 1; b_req = 1; b_we = 0; b_addr = 2; rdy = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin a_req = 0; b_req = 0; end
      ph = k % 4; tx = k / 4;
`ifdef GPR_ARB_FIXED_PRIO_EN
      exp_bg = 1'b0;
`else
      exp_bg = (ph != 0) && (tx % 2 == 1);
`endif
      exp_ag = (ph != 0) && !exp_bg;
      exp_cs = (ph == 1) || (ph == 2);
      #1 check($sformatf("cont%0d", k),
               {66'h0, cs, a_gnt, b_gnt, a_done, b_done},
               {66'h0, exp_cs, exp_ag, exp_bg, exp_ag && ph == 3, exp_bg && ph == 3});
      @(negedge clk);
    end
    #1 check("cont_rdata", {55'h0, a_rdata, b_rdata}, {55'h0, 16'h0, 16'h1234});

    // Reset during a B read in XFER.
    @(negedge clk);
    b_req = 1; b_addr = 2;
    @(negedge clk);
    b_req = 0;
    #1 check1("rst_cmd_bgnt", b_gnt, 1'b1);
    @(negedge clk);
    rst = 1;
    #1 check1("rst_xfer_cs", cs, 1'b1);
    @(negedge clk);
    rst = 0; a_req = 1; b_req = 1; rdy = 0;
    #1 check("rst_after", actual(), 71'h0);
    @(negedge clk);
    rdy = 1;
    #1 check("rst_rdy_wait", actual(), 71'h0);
    @(negedge clk);
    a_req = 0; b_req = 0;
    #1 check("rst_first_grant", {69'h0, a_gnt, b_gnt}, {69'h0, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpr_arbiter.md
# gpr_arbiter

Two-port arbiter and sequencer for the 8-entry, 16-bit general-purpose register bank. The arbiter lets the core datapath (port A) and the debug/loader path (port B) share the bank's single `cs`/`read`/`address`/`data` interface. It serialises accesses and generates the bank's command timing. It returns read data and a completion pulse to whichever port was granted. It sits between the requesters and the register bank. The top level merges `gpr_wdata`/`gpr_wdata_oe` onto the bank's bidirectional data bus.

## Interface
- `DATA_WIDTH`, 16, register and data-bus width
- `ADDR_WIDTH`, 16, width of the bank address port; register select is zero-extended into it
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `a_req`, `b_req`  in  1  access request; held until the matching `*_gnt`
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_addr`, `b_addr`  in  3  register select 0..7
- `a_wdata`, `b_wdata`  in  DATA_WIDTH  write data
- `a_gnt`, `b_gnt`  out  1  high while that port owns the bank
- `a_done`, `b_done`  out  1  one-cycle completion pulse
- `a_rdata`, `b_rdata`  out  DATA_WIDTH  last read result for that port (registered)
- `gpr_cs`  out  1  bank chip select
- `gpr_read`  out  1  bank read strobe (1 = read)
- `gpr_address`  out  ADDR_WIDTH  `{zeros, sel[2:0]}`
- `gpr_wdata`  out  DATA_WIDTH  write data toward the bank bus
- `gpr_wdata_oe`  out  1  top level drives the bank bus with `gpr_wdata` when high
- `gpr_rdata`  in  DATA_WIDTH  bank bus as seen by the arbiter
- `gpr_rdy`  in  1  bank idle indicator

## Operation
- **FSM states:** IDLE → CMD → XFER → RECOV → IDLE. There is no other path except reset.
- **IDLE**
  - All bank outputs are 0.
  - If `gpr_rdy`=1 and any request is present, pick a winner, latch its we/addr/wdata into command registers, and go to CMD.
  - Otherwise stay in IDLE.
- **CMD and XFER**
  - `gpr_cs`=1.
  - `gpr_read`=~we.
  - `gpr_address` and `gpr_wdata` come from the command registers.
  - `gpr_wdata_oe`=`gpr_cs & we`. The arbiter never drives the bus on reads.
- **Read capture:** on the clock edge leaving XFER, if the access is a read, `gpr_rdata` is registered into the winner's `*_rdata`.
- **RECOV**
  - `gpr_cs`=0.
  - Winner's `*_done`=1 for exactly this cycle.
  - Last-grant pointer updated to the winner.
- **Grant:** the winner's `*_gnt` is high in CMD, XFER and RECOV, and only one `*_gnt` is high at a time.
- **Arbitration:** round-robin. With both ports requesting, the port not granted last wins. With a single requester, that port wins.
- **Read data retention:** `*_rdata` holds its value until the next read by the same port. Writes and other-port accesses leave it unchanged.
- **Back-to-back requests:** if a request is still high in IDLE after `done`, it is a new transaction. Maximum rate is one access per 4 cycles.
- **Requester inputs:** may change freely once `*_gnt` rises, because the command registers are latched at grant.

## Timing
- **Reset values:**
  - State IDLE.
  - All outputs 0, including `gpr_address`, both `*_rdata`, both `*_gnt` and both `*_done`.
  - Last-grant = B, so A wins the first contention.
- **Latency:** request seen at edge N (IDLE) → CMD during cycle N+1 → XFER during N+2 → `done` and `rdata` valid during N+3.
- **`gpr_cs` shape:** exactly 2 cycles high per access, and never high in consecutive transactions without the intervening RECOV/IDLE low cycles.
- **`gpr_rdy`=0 in IDLE:** blocks the grant. It is sampled only in IDLE.
- **Requests outside IDLE:** ignored.
- **Reset mid-operation:**
  - Next cycle is IDLE with all outputs 0.
  - No `done` pulse.
  - `*_rdata` cleared.
  - The next grant waits for `gpr_rdy`=1.

## Configuration
- `GPR_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority. Port A always wins contention, and B is granted only when `a_req`=0 in IDLE. The last-grant pointer is unused.
  - **Undefined (default):** round-robin as above.

## Test plan
- **Single write:**
  - Stimulus: after reset, `a_req`=1, `a_we`=1, `a_addr`=5, `a_wdata`=16'hA5A5.
  - Required: `gpr_cs` and `gpr_wdata_oe` high for cycles 1–2; `gpr_read`=0; `gpr_address`=16'h0005; `a_gnt` high for cycles 1–3; `a_done` pulse in cycle 3; `b_*` all 0.
- **Read-back:**
  - Stimulus: after the write, A reads reg 5.
  - Required: `gpr_read`=1 and `gpr_wdata_oe`=0 for cycles 1–2; `a_rdata`=16'hA5A5 with `a_done` in cycle 3; `b_rdata` unchanged.
- **Contention:**
  - Stimulus: `a_req` and `b_req` held high, reads of regs 1 and 2.
  - Required (default): grants A,B,A,B, with a `done` every 4 cycles.
  - Required (`GPR_ARB_FIXED_PRIO_EN`): A,A,A and no `b_gnt`.
- **Bank busy:**
  - Stimulus: `gpr_rdy`=0 for 5 cycles with `b_req`=1.
  - Required: no `gpr_cs`, no `b_gnt`; CMD starts the cycle after `gpr_rdy` returns to 1.
- **Reset in XFER:**
  - Stimulus: assert `reset` for 1 cycle during a B read.
  - Required: `gpr_cs`=0 and `b_gnt`=0 next cycle; no `b_done`; `b_rdata`=0; with both ports requesting afterwards, A is granted first.
